// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants and state type for the wave waitcnt tracker
package wave_pkg;
  localparam int W_DEF   = 8;
  localparam int VMW_DEF = 6;
  localparam int LGW_DEF = 4;

  localparam logic MEM_VMEM = 1'b0;
  localparam logic MEM_LGKM = 1'b1;

  typedef enum logic {
    WC_RUN  = 1'b0,
    WC_WAIT = 1'b1
  } wc_state_t;
endpackage

// File: rtl/wave_waitcnt_slot.sv
// rtl/wave_waitcnt_slot.sv - outstanding-memory counters and s_waitcnt FSM for one wave slot
module wave_waitcnt_slot
  import wave_pkg::*;
#(
  parameter int VMW = VMW_DEF,
  parameter int LGW = LGW_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           vm_inc,
  input  logic           vm_dec,
  input  logic           lg_inc,
  input  logic           lg_dec,
  input  logic           wait_set,
  input  logic [VMW-1:0] wait_vm,
  input  logic [LGW-1:0] wait_lg,
  input  logic           clr,
  output logic           ready,
  output logic           full,
  output logic           ovf,
  output logic           unf
);
  localparam logic [VMW-1:0] VM_MAX = '1;
  localparam logic [LGW-1:0] LG_MAX = '1;

  wc_state_t      state;
  logic [VMW-1:0] vm_cnt, vm_next, thr_vm;
  logic [LGW-1:0] lg_cnt, lg_next, thr_lg;
  logic           vm_ovf, vm_unf, lg_ovf, lg_unf;

  // A same-cycle inc and dec cancel, so saturation only applies to a lone inc or dec.
  assign vm_ovf = vm_inc & ~vm_dec & (vm_cnt == VM_MAX);
  assign vm_unf = vm_dec & ~vm_inc & (vm_cnt == '0);
  assign lg_ovf = lg_inc & ~lg_dec & (lg_cnt == LG_MAX);
  assign lg_unf = lg_dec & ~lg_inc & (lg_cnt == '0);

  assign ovf = ~clr & (vm_ovf | lg_ovf);
  assign unf = ~clr & (vm_unf | lg_unf);

  always_comb begin
    vm_next = vm_cnt;
    if (vm_inc && !vm_dec && !vm_ovf) vm_next = vm_cnt + VMW'(1);
    else if (vm_dec && !vm_inc && !vm_unf) vm_next = vm_cnt - VMW'(1);
  end

  always_comb begin
    lg_next = lg_cnt;
    if (lg_inc && !lg_dec && !lg_ovf) lg_next = lg_cnt + LGW'(1);
    else if (lg_dec && !lg_inc && !lg_unf) lg_next = lg_cnt - LGW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= WC_RUN;
      vm_cnt <= '0;
      lg_cnt <= '0;
      thr_vm <= '0;
      thr_lg <= '0;
    end else if (clr) begin
      state  <= WC_RUN;
      vm_cnt <= '0;
      lg_cnt <= '0;
      thr_vm <= '0;
      thr_lg <= '0;
    end else begin
      vm_cnt <= vm_next;
      lg_cnt <= lg_next;
      // Release compares registered counters, so a wait never clears before N+2.
      if (wait_set) begin
        state  <= WC_WAIT;
        thr_vm <= wait_vm;
        thr_lg <= wait_lg;
      end else if (state == WC_WAIT && vm_cnt <= thr_vm && lg_cnt <= thr_lg) begin
        state <= WC_RUN;
      end
    end
  end

  assign ready = (state == WC_RUN);
  assign full  = (vm_cnt == VM_MAX) | (lg_cnt == LG_MAX);
endmodule

// File: rtl/wave_waitcnt_tracker.sv
// rtl/wave_waitcnt_tracker.sv - per-wave waitcnt tracking driving the scheduler ready mask
module wave_waitcnt_tracker
  import wave_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int IDW = (W > 1) ? $clog2(W) : 1,
  parameter int VMW = VMW_DEF,
  parameter int LGW = LGW_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           mem_iss_valid,
  input  logic [IDW-1:0] mem_iss_id,
  input  logic           mem_iss_lgkm,
  input  logic           vm_ret_valid,
  input  logic [IDW-1:0] vm_ret_id,
  input  logic           lg_ret_valid,
  input  logic [IDW-1:0] lg_ret_id,
  input  logic           wait_valid,
  input  logic [IDW-1:0] wait_id,
  input  logic [VMW-1:0] wait_vm,
  input  logic [LGW-1:0] wait_lg,
  input  logic           clr_valid,
  input  logic [IDW-1:0] clr_id,
  output logic [W-1:0]   wave_ready,
  output logic [W-1:0]   mem_full,
  output logic           err_ovf,
  output logic           err_unf
);
  logic [W-1:0] ovf_p, unf_p;

  // Ids at or above W match no slot, so such events vanish without error.
  for (genvar i = 0; i < W; i++) begin : g_slot
    logic iss_hit;
    assign iss_hit = mem_iss_valid && (mem_iss_id == IDW'(i));

    wave_waitcnt_slot #(.VMW(VMW), .LGW(LGW)) u_slot (
      .clk      (clk),
      .rstn     (rstn),
      .vm_inc   (iss_hit && (mem_iss_lgkm == MEM_VMEM)),
      .vm_dec   (vm_ret_valid && (vm_ret_id == IDW'(i))),
      .lg_inc   (iss_hit && (mem_iss_lgkm == MEM_LGKM)),
      .lg_dec   (lg_ret_valid && (lg_ret_id == IDW'(i))),
      .wait_set (wait_valid && (wait_id == IDW'(i))),
      .wait_vm  (wait_vm),
      .wait_lg  (wait_lg),
      .clr      (clr_valid && (clr_id == IDW'(i))),
      .ready    (wave_ready[i]),
      .full     (mem_full[i]),
      .ovf      (ovf_p[i]),
      .unf      (unf_p[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (|ovf_p) err_ovf <= 1'b1;
      if (|unf_p) err_unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wave_waitcnt_tracker.sv
// tb/tb_wave_waitcnt_tracker.sv - self-checking bench for wave_waitcnt_tracker
module tb_wave_waitcnt_tracker;
  localparam int W = 8, IDW = 3, VMW = 6, LGW = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           mem_iss_valid, mem_iss_lgkm, vm_ret_valid, lg_ret_valid, wait_valid, clr_valid;
  logic [IDW-1:0] mem_iss_id, vm_ret_id, lg_ret_id, wait_id, clr_id;
  logic [VMW-1:0] wait_vm;
  logic [LGW-1:0] wait_lg;
  logic [W-1:0]   wave_ready, mem_full;
  logic           err_ovf, err_unf;

  always #5 clk = ~clk;

  wave_waitcnt_tracker #(.W(W), .IDW(IDW), .VMW(VMW), .LGW(LGW)) dut (
    .clk(clk), .rstn(rstn),
    .mem_iss_valid(mem_iss_valid), .mem_iss_id(mem_iss_id), .mem_iss_lgkm(mem_iss_lgkm),
    .vm_ret_valid(vm_ret_valid), .vm_ret_id(vm_ret_id),
    .lg_ret_valid(lg_ret_valid), .lg_ret_id(lg_ret_id),
    .wait_valid(wait_valid), .wait_id(wait_id), .wait_vm(wait_vm), .wait_lg(wait_lg),
    .clr_valid(clr_valid), .clr_id(clr_id),
    .wave_ready(wave_ready), .mem_full(mem_full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  typedef enum int {
    OP_NOP, OP_ISS_VM, OP_ISS_LG, OP_RET_VM, OP_RET_LG, OP_WAIT, OP_CLR, OP_ISSRET_VM, OP_CLR_RETVM
  } op_t;

  typedef struct {
    op_t        op;
    int         id;
    int         vm;
    int         lg;
    logic [7:0] e_ready;
    logic [7:0] e_full;
    logic       e_ovf;
    logic       e_unf;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] ready;
    logic [7:0] full;
    logic       ovf;
    logic       unf;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] r, input logic [7:0] f,
                           input logic o, input logic u);
    check({name, "_ready"}, wave_ready, r);
    check({name, "_full"}, mem_full, f);
    check({name, "_ovf"}, 8'(err_ovf), 8'(o));
    check({name, "_unf"}, 8'(err_unf), 8'(u));
  endtask

  task automatic add(input op_t op, input int id, input int vm, input int lg,
                     input logic [7:0] er, input logic [7:0] ef, input logic eo, input logic eu,
                     input string name);
    vec_t v;
    v.op = op; v.id = id; v.vm = vm; v.lg = lg;
    v.e_ready = er; v.e_full = ef; v.e_ovf = eo; v.e_unf = eu; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    mem_iss_valid = 0; mem_iss_id = '0; mem_iss_lgkm = 0;
    vm_ret_valid = 0; vm_ret_id = '0; lg_ret_valid = 0; lg_ret_id = '0;
    wait_valid = 0; wait_id = '0; wait_vm = '0; wait_lg = '0;
    clr_valid = 0; clr_id = '0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    case (v.op)
      OP_ISS_VM:    begin mem_iss_valid = 1; mem_iss_id = 3'(v.id); mem_iss_lgkm = 0; end
      OP_ISS_LG:    begin mem_iss_valid = 1; mem_iss_id = 3'(v.id); mem_iss_lgkm = 1; end
      OP_RET_VM:    begin vm_ret_valid = 1; vm_ret_id = 3'(v.id); end
      OP_RET_LG:    begin lg_ret_valid = 1; lg_ret_id = 3'(v.id); end
      OP_WAIT:      begin wait_valid = 1; wait_id = 3'(v.id); wait_vm = 6'(v.vm); wait_lg = 4'(v.lg); end
      OP_CLR:       begin clr_valid = 1; clr_id = 3'(v.id); end
      OP_ISSRET_VM: begin
        mem_iss_valid = 1; mem_iss_id = 3'(v.id); mem_iss_lgkm = 0;
        vm_ret_valid = 1; vm_ret_id = 3'(v.id);
      end
      OP_CLR_RETVM: begin clr_valid = 1; clr_id = 3'(v.id); vm_ret_valid = 1; vm_ret_id = 3'(v.id); end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    vec_t v;
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'hFF, 8'h00, 1'b0, 1'b0);
    rstn = 1'b1;

    // Wave 3: VMEM wait with two outstanding ops, released two cycles after the last return.
    add(OP_ISS_VM, 3, 0, 0, 8'hFF, 8'h00, 0, 0, "t2_iss_a");
    add(OP_ISS_VM, 3, 0, 0, 8'hFF, 8'h00, 0, 0, "t2_iss_b");
    add(OP_WAIT, 3, 0, 15, 8'hF7, 8'h00, 0, 0, "t2_n1");
    add(OP_NOP, 0, 0, 0, 8'hF7, 8'h00, 0, 0, "t2_n2");
    add(OP_NOP, 0, 0, 0, 8'hF7, 8'h00, 0, 0, "t2_n3");
    add(OP_RET_VM, 3, 0, 0, 8'hF7, 8'h00, 0, 0, "t2_n4");
    add(OP_NOP, 0, 0, 0, 8'hF7, 8'h00, 0, 0, "t2_n5");
    add(OP_RET_VM, 3, 0, 0, 8'hF7, 8'h00, 0, 0, "t2_n6");
    add(OP_NOP, 0, 0, 0, 8'hFF, 8'h00, 0, 0, "t2_n7");
    // Wave 5: already-satisfied wait still blocks for exactly one cycle.
    add(OP_WAIT, 5, 0, 0, 8'hDF, 8'h00, 0, 0, "t3_n1");
    add(OP_NOP, 0, 0, 0, 8'hFF, 8'h00, 0, 0, "t3_n2");
    // Wave 7: clear beats a same-cycle return and drops the wait.
    for (int k = 0; k < 4; k++) add(OP_ISS_VM, 7, 0, 0, 8'hFF, 8'h00, 0, 0, "t6_iss");
    add(OP_WAIT, 7, 0, 0, 8'h7F, 8'h00, 0, 0, "t6_wait");
    add(OP_NOP, 0, 0, 0, 8'h7F, 8'h00, 0, 0, "t6_held");
    add(OP_CLR_RETVM, 7, 0, 0, 8'hFF, 8'h00, 0, 0, "t6_clr");
    add(OP_WAIT, 7, 0, 0, 8'h7F, 8'h00, 0, 0, "t6_rewait");
    add(OP_NOP, 0, 0, 0, 8'hFF, 8'h00, 0, 0, "t6_cnt_zero");
    // Wave 2: issue+return cancel; lone LGKM return at zero underflows.
    add(OP_ISS_VM, 2, 0, 0, 8'hFF, 8'h00, 0, 0, "t4_iss");
    add(OP_ISSRET_VM, 2, 0, 0, 8'hFF, 8'h00, 0, 0, "t4_issret");
    add(OP_RET_VM, 2, 0, 0, 8'hFF, 8'h00, 0, 0, "t4_vm_was_1");
    add(OP_RET_LG, 2, 0, 0, 8'hFF, 8'h00, 0, 1, "t4_unf");
    add(OP_NOP, 0, 0, 0, 8'hFF, 8'h00, 0, 1, "t4_unf_sticky");
    // Wave 0: LGKM counter saturates at 15.
    for (int k = 1; k <= 14; k++) add(OP_ISS_LG, 0, 0, 0, 8'hFF, 8'h00, 0, 1, "t5_fill");
    add(OP_ISS_LG, 0, 0, 0, 8'hFF, 8'h01, 0, 1, "t5_full");
    add(OP_ISS_LG, 0, 0, 0, 8'hFF, 8'h01, 1, 1, "t5_ovf");
    add(OP_NOP, 0, 0, 0, 8'hFF, 8'h01, 1, 1, "t5_hold");
    add(OP_CLR, 0, 0, 0, 8'hFF, 8'h00, 1, 1, "t5_clr");

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      sb.push_back('{v.e_ready, v.e_full, v.e_ovf, v.e_unf, v.name});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(e.name, e.ready, e.full, e.ovf, e.unf);
    end
    idle_inputs();

    // Asynchronous reset while wave 6 is blocked.
    v.op = OP_ISS_VM; v.id = 6; v.vm = 0; v.lg = 0;
    drive(v);
    @(posedge clk);
    #1;
    v.op = OP_WAIT;
    drive(v);
    @(posedge clk);
    #1;
    idle_inputs();
    check_all("rst_pre", 8'hBF, 8'h00, 1'b1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all("rst_async", 8'hFF, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_after", 8'hFF, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
